// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit, one bit per cycle.
//   MUL*      : radix-2 shift-add on operand magnitudes.
//   DIV*/REM* : restoring division on operand magnitudes.
//   Signs are reapplied when the result is formed on entry to DONE.
// Optional build macro: MULDIV_FAST_SPECIAL_EN
//   Divide-by-zero and signed overflow skip CALC and finish one cycle
//   after start. Result values are the same with or without it.
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   funct3 in   RV32M operation select
//   op_a   in   rs1 value (multiplicand / dividend)
//   op_b   in   rs2 value (multiplier / divisor)
//   kill   in   abort the operation in flight
//   busy   out  high in CALC and DONE
//   done   out  one-cycle pulse while result is valid
//   result out  final result, held until the next completed operation
module mul_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       f3_q,     f3_d;
  logic             sign_a_q, sign_a_d;
  logic             neg_q,    neg_d;
  logic             zero_q,   zero_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic [W-1:0]     hi_q,     hi_d;
  logic [W-1:0]     lo_q,     lo_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [W-1:0]     result_q, result_d;

  // Operand decode for the start cycle
  logic         signed_a_in, signed_b_in;
  logic         sign_a_in, sign_b_in;
  logic [W-1:0] mag_a_in, mag_b_in;
  logic         zero_in;

  always_comb begin
    signed_a_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    signed_b_in = signed_a_in && (funct3 != 3'b010);
    sign_a_in   = signed_a_in & op_a[W-1];
    sign_b_in   = signed_b_in & op_b[W-1];
    mag_a_in    = sign_a_in ? W'(~op_a + W'(1)) : op_a;
    mag_b_in    = sign_b_in ? W'(~op_b + W'(1)) : op_b;
    zero_in     = (op_b == '0);
  end

  // Special divide cases resolved straight from the inputs
  logic         fast_take;
  logic [W-1:0] fast_res;
`ifdef MULDIV_FAST_SPECIAL_EN
  logic ovf_in;
  assign ovf_in    = (funct3[2] & ~funct3[0]) && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
  assign fast_take = funct3[2] & (zero_in | ovf_in);
  assign fast_res  = zero_in ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  // One iteration step of both datapaths
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic         div_ok;
  logic [W-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[W-1]};
    div_ok    = (div_shift >= {1'b0, b_q});
    if (f3_q[2]) begin
      hi_n = div_ok ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
      lo_n = {lo_q[W-2:0], div_ok};
    end else begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign fix-up and result selection after the final iteration
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s, a_orig, fin;

  always_comb begin
    prod_s = neg_q ? (2*W)'(~{hi_n, lo_n} + (2*W)'(1)) : {hi_n, lo_n};
    quo_s  = neg_q    ? W'(~lo_n + W'(1)) : lo_n;
    rem_s  = sign_a_q ? W'(~hi_n + W'(1)) : hi_n;
    a_orig = sign_a_q ? W'(~a_q + W'(1))  : a_q;
    if (!f3_q[2]) begin
      fin = (f3_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    end else if (f3_q[1]) begin
      fin = zero_q ? a_orig : rem_s;
    end else begin
      fin = zero_q ? '1 : quo_s;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d     = funct3;
          sign_a_d = sign_a_in;
          neg_d    = sign_a_in ^ sign_b_in;
          zero_d   = zero_in;
          a_d      = mag_a_in;
          b_d      = mag_b_in;
          hi_d     = '0;
          lo_d     = funct3[2] ? mag_a_in : mag_b_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (fast_take) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = fast_res;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          busy_d = 1'b1;
          hi_d   = hi_n;
          lo_d   = lo_n;
          if (cnt_q == CNT_W'(W - 1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            done_d   = 1'b1;
            result_d = fin;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  // A kill arriving in the DONE cycle still retracts the pulse
  assign done   = done_q & ~kill;
  assign result = result_q;

endmodule
